and_op_monitor: RTL and testbench
=================================

AND_OP_MONITOR -- requirements
Module: and_op_monitor

Interface
REQ-001 Parameter: CNT_W, 8, width of the sample and error counters.
REQ-002 Parameter: NUM_SAMPLES, 16, number of accepted samples that completes a run (1 .. 2^CNT_W-1).
REQ-003 Parameter: MAX_ERR, 4, error count that forces the FAIL state (1 .. 2^CNT_W-1).
REQ-004 Port: clk  input  1  single clock; every register updates on its rising edge.
REQ-005 Port: rst  input  1  reset, synchronous and active-high.
REQ-006 Port: start  input  1  one-cycle request that clears the counters and begins a run.
REQ-007 Port: abort  input  1  ends a run and returns the FSM to IDLE.
REQ-008 Port: valid  input  1  marks the current b, c, a triple as a sample.
REQ-009 Port: b  input  1  first operand driven to the AND gate under observation.
REQ-010 Port: c  input  1  second operand driven to the AND gate under observation.
REQ-011 Port: a  input  1  AND gate output as observed.
REQ-012 Port: busy  output  1  high while the state is RUN.
REQ-013 Port: done  output  1  high while the state is DONE.
REQ-014 Port: fail  output  1  high while the state is FAIL.
REQ-015 Port: mismatch  output  1  one-cycle pulse for each failing sample.
REQ-016 Port: sample_cnt  output  CNT_W  number of samples accepted in the current or last run.
REQ-017 Port: err_cnt  output  CNT_W  number of mismatches in the current or last run.

Function
REQ-018 FSM states: IDLE, RUN, DONE, FAIL; busy, done and fail are decoded directly from the state register.
REQ-019 Start: start in IDLE, DONE or FAIL moves the FSM to RUN and clears sample_cnt and err_cnt on the same edge. start while in RUN is ignored.
REQ-020 Sample acceptance: a sample is accepted only when the FSM is in RUN, valid=1 and abort=0. Samples offered in any other state are ignored.
REQ-021 Expected value: the expected output is b & c. A sample mismatches when a differs from b & c, or when any of a, b, c is X or Z (4-state comparison, so an X/Z counts as an error).
REQ-022 Each accepted sample increments sample_cnt by 1 on that edge.
REQ-023 Each mismatching accepted sample increments err_cnt by 1 on that edge.
REQ-024 mismatch is registered: it is high for exactly the one cycle after the failing sample and low otherwise.
REQ-025 Both counters saturate at 2^CNT_W-1 and never wrap.
REQ-026 RUN to FAIL: taken on the edge where the accepted sample brings err_cnt to MAX_ERR.
REQ-027 RUN to DONE: taken on the edge where the accepted sample brings sample_cnt to NUM_SAMPLES, provided FAIL is not also taken.
REQ-028 Simultaneous: if the final sample also reaches MAX_ERR, the FSM goes to FAIL, not DONE.
REQ-029 abort in RUN moves the FSM to IDLE on the next edge. The counters hold their values, and any sample offered in that cycle is discarded.
REQ-030 abort outside RUN has no effect. start and abort asserted together in RUN are treated as abort only.
REQ-031 DONE and FAIL are held, with the counters frozen, until start or rst.
REQ-032 No combinational path exists from any input to any output.

Reset
REQ-033 While rst=1: state=IDLE, sample_cnt=0, err_cnt=0, mismatch=0, busy=0, done=0, fail=0. rst overrides start, abort and valid.
REQ-034 rst asserted mid-run discards the run in progress. After rst is released, the next run starts only on a new start.

Verification
REQ-035 Clean run: start, then 16 valid samples cycling b,c through 00,01,10,11 with a=b&c -> after the 16th edge done=1, sample_cnt=16, err_cnt=0, mismatch never asserted.
REQ-036 Error burst: start, then samples 3, 7, 9 and 12 with a inverted -> mismatch pulses one cycle after each; after the 12th sample fail=1, err_cnt=4, sample_cnt=12; further valid samples are ignored.
REQ-037 Simultaneous final: MAX_ERR=1, NUM_SAMPLES=4, only sample 4 wrong -> FSM goes to FAIL, fail=1, done=0, sample_cnt=4, err_cnt=1.
REQ-038 X handling: sample with b=1, c=1, a=X -> counted as a mismatch, err_cnt increments by 1.
REQ-039 Abort and restart: abort after 5 samples -> IDLE with sample_cnt=5; a later start -> RUN with both counters cleared to 0 on that edge.
REQ-040 Reset mid-run: rst for one cycle after 6 samples with 2 errors -> all outputs 0 and state IDLE; valid samples are ignored until the next start.

Source files
------------

// File: rtl/and_op_monitor.sv
// Run-based checker for a 2-input AND gate: counts accepted samples and
// mismatches against b & c, ending a run in DONE (enough samples) or FAIL (too many errors).
module and_op_monitor #(
    parameter int CNT_W       = 8,
    parameter int NUM_SAMPLES = 16,
    parameter int MAX_ERR     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             valid,
    input  logic             b,
    input  logic             c,
    input  logic             a,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic             mismatch,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    // state   | meaning
    // IDLE    | no run active, counters hold last run
    // RUN     | accepting samples
    // DONE    | NUM_SAMPLES accepted without reaching MAX_ERR
    // FAIL    | MAX_ERR mismatches reached
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] NUM_LAST = CNT_W'(NUM_SAMPLES);
    localparam logic [CNT_W-1:0] ERR_LAST = CNT_W'(MAX_ERR);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_sample_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] w_sample_inc;
    logic [CNT_W-1:0] w_err_inc;
    logic             r_mismatch;
    logic             w_accept;
    logic             w_bad;
    logic             w_clear;

    always_comb begin
        w_accept     = (r_state == ST_RUN) && valid && !abort;
        // X/Z on any operand must count as an error, not compare equal
        w_bad        = (a !== (b & c)) || $isunknown({a, b, c});
        w_clear      = (r_state != ST_RUN) && start;
        w_sample_inc = (r_sample_cnt == CNT_MAX) ? r_sample_cnt : r_sample_cnt + 1'b1;
        w_err_inc    = (r_err_cnt == CNT_MAX) ? r_err_cnt : r_err_cnt + 1'b1;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_accept) begin
                    // FAIL wins when the last sample also hits the error limit
                    if (w_bad && (w_err_inc == ERR_LAST)) w_state_next = ST_FAIL;
                    else if (w_sample_inc == NUM_LAST)     w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sample_cnt <= '0;
            r_err_cnt    <= '0;
            r_mismatch   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_mismatch <= w_accept && w_bad;
            if (w_clear) begin
                r_sample_cnt <= '0;
                r_err_cnt    <= '0;
            end else if (w_accept) begin
                r_sample_cnt <= w_sample_inc;
                if (w_bad) r_err_cnt <= w_err_inc;
            end
        end
    end

    assign busy       = (r_state == ST_RUN);
    assign done       = (r_state == ST_DONE);
    assign fail       = (r_state == ST_FAIL);
    assign mismatch   = r_mismatch;
    assign sample_cnt = r_sample_cnt;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_and_op_monitor.sv
// Directed vector bench for and_op_monitor: a default instance driven from a
// vector table, plus a MAX_ERR=1/NUM_SAMPLES=4 instance for the simultaneous-final case.
module tb_and_op_monitor;

    logic       clk = 1'b0;
    logic       rst, start, abort, valid, b, c, a;
    logic       busy, done, fail, mismatch;
    logic [7:0] sample_cnt, err_cnt;

    logic       start2, abort2, valid2, b2, c2, a2;
    logic       busy2, done2, fail2, mismatch2;
    logic [7:0] sample_cnt2, err_cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    and_op_monitor #(.CNT_W(8), .NUM_SAMPLES(16), .MAX_ERR(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .valid(valid),
        .b(b), .c(c), .a(a), .busy(busy), .done(done), .fail(fail),
        .mismatch(mismatch), .sample_cnt(sample_cnt), .err_cnt(err_cnt)
    );

    and_op_monitor #(.CNT_W(8), .NUM_SAMPLES(4), .MAX_ERR(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .valid(valid2),
        .b(b2), .c(c2), .a(a2), .busy(busy2), .done(done2), .fail(fail2),
        .mismatch(mismatch2), .sample_cnt(sample_cnt2), .err_cnt(err_cnt2)
    );

    typedef struct {
        logic rst, start, abort, valid, b, c, a;
        logic busy, done, fail, mm;
        int   sc, ec;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, st, ab, v, bi, ci, ai,
                       input logic bu, dn, fl, mm, input int sc, input int ec);
        vec_t t;
        t.rst = r; t.start = st; t.abort = ab; t.valid = v;
        t.b = bi; t.c = ci; t.a = ai;
        t.busy = bu; t.done = dn; t.fail = fl; t.mm = mm;
        t.sc = sc; t.ec = ec;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s (step %0d): got %0d want %0d", name, idx, got, want);
        end
    endtask

    task automatic chk_all(input int idx, input logic bu, dn, fl, mm, input int sc, input int ec);
        chk("busy", idx, int'(busy), int'(bu));
        chk("done", idx, int'(done), int'(dn));
        chk("fail", idx, int'(fail), int'(fl));
        chk("mismatch", idx, int'(mismatch), int'(mm));
        chk("sample_cnt", idx, int'(sample_cnt), sc);
        chk("err_cnt", idx, int'(err_cnt), ec);
    endtask

    task automatic step2(input logic st, v, bi, ci, ai);
        start2 = st; valid2 = v; b2 = bi; c2 = ci; a2 = ai;
        @(posedge clk); #1;
    endtask

    initial begin
        int e;
        logic bb, cc, er;

        // clean run: 16 good samples cycling 00,01,10,11
        add(0,1,0,0,0,0,0, 1,0,0,0, 0,0);
        for (int i = 1; i <= 16; i++) begin
            bb = 1'((i - 1) >> 1); cc = 1'(i - 1);
            add(0,0,0,1,bb,cc,bb & cc, i < 16, i == 16, 0, 0, i, 0);
        end
        add(0,0,0,1,1,1,0, 0,1,0,0, 16,0);

        // error burst on samples 3,7,9,12
        add(0,1,0,0,0,0,0, 1,0,0,0, 0,0);
        e = 0;
        for (int i = 1; i <= 12; i++) begin
            er = (i == 3 || i == 7 || i == 9 || i == 12);
            bb = 1'(i); cc = 1'(i >> 1);
            if (er) e++;
            add(0,0,0,1,bb,cc,(bb & cc) ^ er, i < 12, 0, i == 12, er, i, e);
        end
        add(0,0,0,1,1,1,0, 0,0,1,0, 12,4);
        add(0,0,0,1,0,1,0, 0,0,1,0, 12,4);

        // X on a with b=c=1
        add(0,1,0,0,0,0,0, 1,0,0,0, 0,0);
        add(0,0,0,1,1,1,1'bx, 1,0,0,1, 1,1);
        add(0,0,0,1,1,0,0, 1,0,0,0, 2,1);
        // start in RUN ignored, sample still taken
        add(0,1,0,1,0,0,0, 1,0,0,0, 3,1);
        // abort discards a bad sample in the same cycle
        add(0,0,1,1,1,1,0, 0,0,0,0, 3,1);

        // abort after 5 samples, then restart
        add(0,1,0,0,0,0,0, 1,0,0,0, 0,0);
        for (int i = 1; i <= 5; i++) add(0,0,0,1,1,1,1, 1,0,0,0, i,0);
        add(0,0,1,1,0,1,0, 0,0,0,0, 5,0);
        add(0,0,1,1,1,1,0, 0,0,0,0, 5,0);
        add(0,1,1,0,0,0,0, 1,0,0,0, 0,0);
        add(0,0,0,1,0,0,1, 1,0,0,1, 1,1);
        add(0,0,0,1,1,0,0, 1,0,0,0, 2,1);
        add(0,1,1,1,1,1,1, 0,0,0,0, 2,1);

        // reset mid-run after 6 samples with errors on 2 and 5
        add(0,1,0,0,0,0,0, 1,0,0,0, 0,0);
        e = 0;
        for (int i = 1; i <= 6; i++) begin
            er = (i == 2 || i == 5);
            if (er) e++;
            add(0,0,0,1,0,1,er, 1,0,0,er, i, e);
        end
        add(1,1,0,1,1,1,0, 0,0,0,0, 0,0);
        add(0,0,0,1,1,1,0, 0,0,0,0, 0,0);
        add(0,0,0,1,0,0,1, 0,0,0,0, 0,0);
        add(0,1,0,0,0,0,0, 1,0,0,0, 0,0);
        add(0,0,0,1,1,1,1, 1,0,0,0, 1,0);

        start = 0; abort = 0; valid = 0; b = 0; c = 0; a = 0;
        start2 = 0; abort2 = 0; valid2 = 0; b2 = 0; c2 = 0; a2 = 0;
        rst = 1;
        @(posedge clk); @(posedge clk); #1;
        chk_all(-1, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; start = vecs[i].start; abort = vecs[i].abort;
            valid = vecs[i].valid; b = vecs[i].b; c = vecs[i].c; a = vecs[i].a;
            @(posedge clk); #1;
            chk_all(i, vecs[i].busy, vecs[i].done, vecs[i].fail, vecs[i].mm, vecs[i].sc, vecs[i].ec);
        end
        rst = 0; start = 0; abort = 0; valid = 0;

        // second instance: final sample is also the first error
        step2(1, 0, 0, 0, 0);
        chk("dut2_busy_start", 0, int'(busy2), 1);
        step2(0, 1, 1, 1, 1);
        step2(0, 1, 0, 1, 0);
        step2(0, 1, 1, 0, 0);
        chk("dut2_busy_3", 3, int'(busy2), 1);
        chk("dut2_sc_3", 3, int'(sample_cnt2), 3);
        step2(0, 1, 1, 1, 0);
        chk("dut2_fail", 4, int'(fail2), 1);
        chk("dut2_done", 4, int'(done2), 0);
        chk("dut2_mismatch", 4, int'(mismatch2), 1);
        chk("dut2_sc", 4, int'(sample_cnt2), 4);
        chk("dut2_ec", 4, int'(err_cnt2), 1);
        step2(0, 1, 1, 1, 0);
        chk("dut2_fail_hold", 5, int'(fail2), 1);
        chk("dut2_ec_hold", 5, int'(err_cnt2), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
